muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, the multi-cycle companion to the instruction decoder's `domul` / `multoreg` / `lohi` controls. It executes mult, multu, div and divu one bit per cycle over a parametrised operand width. It holds results in HI/LO for mfhi/mflo and accepts direct HI/LO writes (mthi/mtlo). The datapath stalls mfhi/mflo and further mul/div issue while `busy` is high.

## Interface
- WIDTH, 32, operand width; even, ≥ 4.

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 multu, 01 mult, 10 divu, 11 div
- a  input  WIDTH  rs operand: multiplicand or dividend
- b  input  WIDTH  rt operand: multiplier or divisor
- wr_hi  input  1  mthi: load HI from wdata
- wr_lo  input  1  mtlo: load LO from wdata
- wdata  input  WIDTH  data for wr_hi / wr_lo
- busy  output  1  operation in progress (state ≠ IDLE), combinational from state
- done  output  1  one-cycle pulse, registered; HI/LO hold the new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- States:
  - IDLE: waits for work.
  - RUN: WIDTH iterations; iteration counter of width clog2(WIDTH).
  - FIX: sign correction and HI/LO writeback.
- IDLE, start=1: latch op, take magnitudes of a and b (signed ops only, else raw), latch sign flags, clear counter and partial result → RUN.
- RUN: one iteration per edge. At counter = WIDTH−1 → FIX, else counter+1.
- Multiply: shift-add on the 2·WIDTH product of the unsigned magnitudes.
  - mult: product negated (two's complement, 2·WIDTH bits) if sign(a) ≠ sign(b).
  - HI = product[2W−1:W], LO = product[W−1:0].
- Divide: restoring division of the magnitudes.
  - div: quotient negated if sign(a) ≠ sign(b); remainder takes sign of a.
  - LO = quotient, HI = remainder.
- Divide by zero (b = 0, div or divu): LO = all ones, HI = a (raw input), normal latency, no error flag.
- Signed overflow (div, most-negative ÷ −1): LO = most-negative, HI = 0.
- FIX: write HI/LO, set done for the following cycle → IDLE.
- wr_hi / wr_lo: take effect at the edge only when state = IDLE; ignored while busy. Both may be asserted together; each loads wdata.
- start together with wr_hi/wr_lo in IDLE: the write happens, then the operation's FIX overwrites it.
- start while busy: ignored, no queuing.
- op = mult or multu with b = 0: ordinary operation, result 0.

## Timing
- Reset (asynchronous, on reset low): state IDLE, counter 0, hi 0, lo 0, done 0, busy 0. Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- start sampled at edge E0 (the launch edge).
- RUN occupies edges E1..E_WIDTH.
- FIX writes HI/LO at edge E_WIDTH+1. done is high from E_WIDTH+1 to E_WIDTH+2.
- Latency is WIDTH+1 cycles, independent of operand values.
- busy is high from E0 to E_WIDTH+1, i.e. WIDTH+1 cycles.
- A new start may be accepted at E_WIDTH+2, the cycle done is high.
- hi/lo keep their old values throughout RUN and change only at FIX or on an IDLE write.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 cycles after the start edge; busy high for 33 cycles.
- mult a=0xFFFFFFFD (−3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then mult 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- div a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x1234, latency 33.
- In IDLE, wr_hi wdata=0xA5A5A5A5 → hi=0xA5A5A5A5. During RUN, pulse wr_lo and start with other operands → both ignored; results match the first operation only.
- Reset asserted at RUN iteration 10 → busy=0 immediately, hi=lo=0, no done pulse. After release, a fresh multu 3×5 → LO=15, HI=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-divide step per cycle, then sign fix-up and HI/LO writeback.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b, b_zero;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] p, p_next;

  logic               in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy = (state != IDLE);

  // Signed ops iterate on magnitudes; sign flags drive the FIX correction.
  assign in_sign_a = op[0] & a[WIDTH-1];
  assign in_sign_b = op[0] & b[WIDTH-1];
  assign in_mag_a  = in_sign_a ? -a : a;
  assign in_mag_b  = in_sign_b ? -b : b;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mag_a : '0)};
    trial   = p[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    p_next  = {mul_sum, p[WIDTH-1:1]};
    if (op_q[1]) begin
      // Restoring step: keep the shifted remainder when the trial borrows.
      if (trial[WIDTH]) p_next = {p[2*WIDTH-2:0], 1'b0};
      else              p_next = {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -p : p;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_zero) begin
        fix_lo = '1;
        fix_hi = sign_a ? -mag_a : mag_a;
      end else begin
        // Most-negative / -1 lands on 0x80..0 naturally after negation.
        fix_lo = (sign_a ^ sign_b) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        fix_hi = sign_a ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      p      <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            op_q   <= op;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            b_zero <= (b == '0);
            cnt    <= '0;
            p      <= {{WIDTH{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return ux * uy;
      2'b01: return 64'(sx * sy);
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit disturb);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    int lat, busy_cnt;
    exp = ref_model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    old_hi = hi; old_lo = lo;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 5) begin
        wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
      end else if (disturb && lat == 6) begin
        wr_lo = 1'b0; start = 1'b0;
      end
      if (done) break;
      if (busy) busy_cnt++;
      if (lat == 16) begin
        check({tag, "_hold_hi"}, {32'b0, hi}, {32'b0, old_hi});
        check({tag, "_hold_lo"}, {32'b0, lo}, {32'b0, old_lo});
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp[63:32]});
    check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp[31:0]});
  endtask

  initial begin
    int done_seen;
    reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #12;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    check("done_pulse_width", {63'b0, done}, 64'd0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_7_2", 2'b10, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0, 1'b0);
    run_op("div_zero", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("mult_b0", 2'b01, 32'h1357_9BDF, 32'd0, 1'b0);

    // Direct HI/LO writes in IDLE.
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("mthi", {32'b0, hi}, 64'hA5A5_A5A5);
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0F0F_1234;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthilo_hi", {32'b0, hi}, 64'h0F0F_1234);
    check("mthilo_lo", {32'b0, lo}, 64'h0F0F_1234);

    run_op("disturbed", 2'b11, 32'hFFFF_8000, 32'd123, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
    end

    // Abort in the middle of RUN.
    @(negedge clk);
    op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_idle_hi", {32'b0, hi}, 64'd0);

    run_op("multu_3x5", 2'b00, 32'd3, 32'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
